// File: rtl/scorecard_regs.sv
// rtl/scorecard_regs.sv - two-player dice scorecard: used masks, upper sums and grand totals.
// Optional upper-section bonus logic is built when SCORECARD_BONUS_EN is defined.
module scorecard_regs #(
    parameter int NUM_CAT      = 12,
    parameter int BONUS_THRESH = 63,
    parameter int BONUS_VAL    = 35
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               new_game,
    input  logic               commit,
    input  logic               player,
    input  logic [3:0]         category,
    input  logic [7:0]         score_in,
    output logic               busy,
    output logic               ack,
    output logic               err,
    output logic [NUM_CAT-1:0] p1_used,
    output logic [NUM_CAT-1:0] p2_used,
    output logic [8:0]         p1_total,
    output logic [8:0]         p2_total,
    output logic               game_over
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_player;
    logic [3:0]         r_cat;
    logic [7:0]         r_score;
    logic               r_err;
    logic [NUM_CAT-1:0] r_used  [2];
    logic [6:0]         r_upper [2];
    logic [8:0]         r_total [2];

    logic [NUM_CAT-1:0] w_onehot;
    logic               w_used_hit;
    logic               w_invalid;
    logic               w_reject;
    logic               w_is_upper;
    logic [6:0]         w_new_upper;
    logic [8:0]         w_bonus_add;
    logic [8:0]         w_new_total;

    // Out-of-range categories shift the one-hot off the top and become all zeros.
    assign w_onehot    = {{(NUM_CAT-1){1'b0}}, 1'b1} << r_cat;
    assign w_used_hit  = |(w_onehot & r_used[r_player]);
    assign w_invalid   = 32'(r_cat) >= NUM_CAT;
    assign w_is_upper  = r_cat < 4'd6;
    assign w_new_upper = w_is_upper ? (r_upper[r_player] + r_score[6:0]) : r_upper[r_player];
    assign w_new_total = r_total[r_player] + {1'b0, r_score} + w_bonus_add;

`ifdef SCORECARD_BONUS_EN
    logic r_bonus_given [2];
    logic w_bonus_hit;

    assign w_bonus_hit = w_is_upper && !r_bonus_given[r_player] &&
                         (w_new_upper >= 7'(BONUS_THRESH));
    assign w_bonus_add = w_bonus_hit ? 9'(BONUS_VAL) : 9'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bonus_given[0] <= 1'b0;
            r_bonus_given[1] <= 1'b0;
        end else if (new_game) begin
            r_bonus_given[0] <= 1'b0;
            r_bonus_given[1] <= 1'b0;
        end else if (r_state == WRITE && w_bonus_hit) begin
            r_bonus_given[r_player] <= 1'b1;
        end
    end
`else
    assign w_bonus_add = 9'd0;
`endif

    always_comb begin
        w_next   = r_state;
        w_reject = 1'b0;
        case (r_state)
            IDLE:  if (commit) w_next = CHECK;
            CHECK: begin
                w_reject = w_invalid | w_used_hit;
                w_next   = w_reject ? IDLE : WRITE;
            end
            WRITE: w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (new_game) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_player <= 1'b0;
            r_cat    <= 4'd0;
            r_score  <= 8'd0;
            r_err    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_used[i]  <= '0;
                r_upper[i] <= '0;
                r_total[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            r_err   <= w_reject & ~new_game;
            if (r_state == IDLE && commit && !new_game) begin
                r_player <= player;
                r_cat    <= category;
                r_score  <= score_in;
            end
            if (new_game) begin
                for (int i = 0; i < 2; i++) begin
                    r_used[i]  <= '0;
                    r_upper[i] <= '0;
                    r_total[i] <= '0;
                end
            end else if (r_state == WRITE) begin
                r_used[r_player]  <= r_used[r_player] | w_onehot;
                r_upper[r_player] <= w_new_upper;
                r_total[r_player] <= w_new_total;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign ack       = (r_state == DONE) && !new_game;
    assign err       = r_err && !new_game;
    assign p1_used   = r_used[0];
    assign p2_used   = r_used[1];
    assign p1_total  = r_total[0];
    assign p2_total  = r_total[1];
    assign game_over = (&r_used[0]) & (&r_used[1]);

endmodule

// File: doc/scorecard_regs.md
SCORECARD_REGS -- requirements
Module: scorecard_regs

Interface
REQ-001 Parameter NUM_CAT, default 12, number of scoring categories (0-5 Ones..Sixes, 6 Choice, 7 Four-of-a-Kind, 8 Full House, 9 Small Straight, 10 Large Straight, 11 Yacht).
REQ-002 Parameter BONUS_THRESH, default 63, upper-section sum at or above which the bonus is awarded.
REQ-003 Parameter BONUS_VAL, default 35, upper-section bonus points.
REQ-004 Port clk  input  1  single system clock; all state on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port new_game  input  1  one-cycle pulse; clears the whole scorecard.
REQ-007 Port commit  input  1  one-cycle pulse; request to record a score.
REQ-008 Port player  input  1  0 = P1, 1 = P2; sampled with commit.
REQ-009 Port category  input  4  target category; sampled with commit.
REQ-010 Port score_in  input  8  calculated score; sampled with commit.
REQ-011 Port busy  output  1  high while a commit is in progress.
REQ-012 Port ack  output  1  one-cycle pulse: commit accepted and totals updated.
REQ-013 Port err  output  1  one-cycle pulse: commit rejected.
REQ-014 Port p1_used / p2_used  output  NUM_CAT each  per-category used flags.
REQ-015 Port p1_total / p2_total  output  9 each  grand totals including bonus.
REQ-016 Port game_over  output  1  high when both used masks are all ones.

Function
REQ-017 FSM states: IDLE, CHECK, WRITE, DONE; encoding is free.
REQ-018 IDLE: commit=1 latches player, category and score_in, then goes to CHECK; busy rises the next cycle.
REQ-019 CHECK: reject if category >= NUM_CAT or if the category is already used for that player: err pulses for one cycle, then IDLE. Otherwise go to WRITE.
REQ-020 WRITE: set the used flag, add the score to the player's total, add it to the player's upper sum if category < 6, then go to DONE.
REQ-021 DONE: ack pulses for one cycle, then IDLE. Commit-to-ack latency is exactly 3 cycles. Commit-to-err latency is exactly 2 cycles.
REQ-022 busy is high in CHECK, WRITE and DONE.
REQ-023 commit while busy is ignored; no queueing and no err.
REQ-024 Upper sum is 7 bits. Totals are 9 bits, with a maximum legal value of 325; no saturation is required.
REQ-025 The bonus is added to the total exactly once, in the WRITE cycle where the upper sum first becomes >= BONUS_THRESH; a per-player bonus_given flag prevents repeats.
REQ-026 game_over is combinational from the used masks.
REQ-027 new_game in any state clears all masks, sums, totals and bonus flags, and returns to IDLE next cycle. It has priority over commit or an in-flight commit, and suppresses ack/err.
REQ-028 A commit that carries score_in=0 is legal and marks the category used.

Reset
REQ-029 While reset_n=0: state=IDLE; busy, ack and err = 0; masks = 0; totals, sums and bonus flags = 0; game_over = 0.
REQ-030 Reset asserted mid-commit aborts the commit with no partial update visible after release.

Configuration
REQ-031 Macro SCORECARD_BONUS_EN: when defined, the bonus logic of REQ-025 is built. When undefined, no bonus flags or bonus adder are built, and totals are the plain sum of committed scores.

Verification
REQ-032 Reset, then commit P1 cat 5 score 30 -> ack at cycle +3, p1_used=12'h020, p1_total=30, p2 unchanged.
REQ-033 Commit P1 cat 5 again -> err at cycle +2, no ack, p1_total still 30.
REQ-034 P1 commits upper scores 3,8,12,16,20,30 (sum 89) -> with SCORECARD_BONUS_EN, total 124 after the sixth ack; without it, 89. A further upper commit adds no second bonus.
REQ-035 Commit with category=12 -> err, masks unchanged. Commit pulse during busy -> ignored, exactly one ack.
REQ-036 Fill all 12 categories for both players -> game_over=1 after the final ack. Then new_game -> masks, totals and game_over = 0 on the next cycle.
REQ-037 Assert new_game in the WRITE cycle of a commit -> no ack, all state cleared.
